// File: rtl/pwm_step_sequencer.sv
// ---------------------------------------------------------------------------
// pwm_step_sequencer
//
// Plays a programmable table of PWM duty values. Each table entry ("step") is
// held for STEP_PERIODS PWM periods. A new duty value is only ever applied on
// the edge where the period counter wraps to 0, so the downstream PWM
// generator never sees a duty change in the middle of a period.
//
// Parameters
//   PWM_INTERVAL : clocks per PWM period
//   STEPS        : number of entries in the pattern table
//   STEP_PERIODS : PWM periods each step is held for
//   LOOP         : 1 = wrap to step 0 after the last step, 0 = stop there
//
// Ports
//   clk          : single clock, all logic on its rising edge
//   rst          : synchronous active-high reset
//   run          : level, 1 = play the pattern, 0 = stop at next period end
//   wr_en        : pattern write strobe (accepted in every state)
//   wr_addr      : pattern write index (out-of-range indices are dropped)
//   wr_data      : duty value to write
//   duty         : compare value for the PWM generator (high clocks/period)
//   period_start : high on every cycle where the period counter is 0
//   step         : index of the step currently applied
//   step_strobe  : one-cycle pulse when a newly loaded duty takes effect
//   busy         : high while arming or playing
//   done         : one-cycle pulse when a non-looping pattern completes
// ---------------------------------------------------------------------------
module pwm_step_sequencer #(
    parameter int PWM_INTERVAL = 1200,
    parameter int STEPS        = 8,
    parameter int STEP_PERIODS = 48,
    parameter int LOOP         = 1,
    localparam int DW = $clog2(PWM_INTERVAL + 1),
    localparam int SW = (STEPS > 1) ? $clog2(STEPS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          run,
    input  logic          wr_en,
    input  logic [SW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    output logic [DW-1:0] duty,
    output logic          period_start,
    output logic [SW-1:0] step,
    output logic          step_strobe,
    output logic          busy,
    output logic          done
);

    localparam int PW = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;

    localparam logic [DW-1:0] CNT_LAST  = DW'(PWM_INTERVAL - 1);
    localparam logic [DW-1:0] DUTY_MAX  = DW'(PWM_INTERVAL);
    localparam logic [PW-1:0] PCNT_LAST = PW'(STEP_PERIODS - 1);
    localparam logic [SW-1:0] STEP_LAST = SW'(STEPS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARM,
        S_PLAY
    } state_t;

    state_t        state_q;
    logic [DW-1:0] cnt_q;
    logic [DW-1:0] cnt_d;
    logic [DW-1:0] pattern_q [STEPS];
    logic [DW-1:0] duty_q;
    logic [SW-1:0] step_q;
    logic [SW-1:0] step_inc;
    logic [PW-1:0] pcnt_q;
    logic          strobe_q;
    logic          done_q;
    logic          boundary;
    logic          wr_ok;

    // A table entry may exceed one full period; clamp to 100 % duty.
    function automatic logic [DW-1:0] sat_duty(input logic [DW-1:0] v);
        return (v > DUTY_MAX) ? DUTY_MAX : v;
    endfunction

    always_comb begin
        boundary = (cnt_q == CNT_LAST);
        cnt_d    = boundary ? '0 : cnt_q + 1'b1;
        // Widened compare so non-power-of-two STEPS still rejects the
        // unused upper indices.
        wr_ok    = ({1'b0, wr_addr} < (SW + 1)'(STEPS));
        step_inc = (step_q == STEP_LAST) ? '0 : step_q + 1'b1;
    end

    // All loads happen on the boundary edge so they first apply at counter 0.
    // Table reads use the pre-edge contents, so a write racing a load of the
    // same entry delivers the old value.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            duty_q   <= '0;
            step_q   <= '0;
            pcnt_q   <= '0;
            strobe_q <= 1'b0;
            done_q   <= 1'b0;
            for (int i = 0; i < STEPS; i++) begin
                pattern_q[i] <= '0;
            end
        end else begin
            cnt_q    <= cnt_d;
            strobe_q <= 1'b0;
            done_q   <= 1'b0;

            if (wr_en && wr_ok) begin
                pattern_q[wr_addr] <= wr_data;
            end

            case (state_q)
                S_IDLE: begin
                    if (run) begin
                        state_q <= S_ARM;
                    end
                end

                S_ARM: begin
                    if (!run) begin
                        state_q <= S_IDLE;
                    end else if (boundary) begin
                        duty_q   <= sat_duty(pattern_q[0]);
                        step_q   <= '0;
                        pcnt_q   <= '0;
                        strobe_q <= 1'b1;
                        state_q  <= S_PLAY;
                    end
                end

                S_PLAY: begin
                    if (boundary) begin
                        if (!run) begin
                            // Stop wins over a pending advance; step is kept.
                            duty_q  <= '0;
                            state_q <= S_IDLE;
                        end else if (pcnt_q == PCNT_LAST) begin
                            pcnt_q <= '0;
                            if ((step_q == STEP_LAST) && (LOOP == 0)) begin
                                duty_q  <= '0;
                                done_q  <= 1'b1;
                                state_q <= S_IDLE;
                            end else begin
                                step_q   <= step_inc;
                                duty_q   <= sat_duty(pattern_q[step_inc]);
                                strobe_q <= 1'b1;
                            end
                        end else begin
                            pcnt_q <= pcnt_q + 1'b1;
                        end
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign duty         = duty_q;
    assign step         = step_q;
    assign step_strobe  = strobe_q;
    assign done         = done_q;
    assign period_start = (cnt_q == '0);
    assign busy         = (state_q != S_IDLE);

endmodule
